// File: rtl/tx10gbe_snap_capture.sv
// Snapshot capture controller for the 10GbE TX stream: arms from software, writes a triggered
// window into a snap BRAM and reports status. Optional circular capture under SNAP_CIRC_EN.
module tx10gbe_snap_capture #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       addr_out,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam int unsigned PadW = 30 - ADDR_W;

  state_e            state_q, state_d;
  logic              en_q;
  logic [2:0]        cfg_q, cfg_d;  // {circ, we_src, trig_src} latched at arming
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [DATA_W-1:0] bdin_q, bdin_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              done_q, done_d;
  logic              wrap_bit;

  logic en_rise, qual, trig_hit, circ_stop, arm, do_write;

  assign en_rise  = ctrl[0] & ~en_q;
  assign qual     = ~cfg_q[1] | din_valid;
  assign trig_hit = ~cfg_q[0] | trig;

`ifdef SNAP_CIRC_EN
  logic wrap_q, wrap_d;
  logic trig_q;

  // A fresh trigger edge terminates an endless circular capture.
  assign circ_stop = cfg_q[2] & trig & ~trig_q;
  assign wrap_bit  = wrap_q;

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      wrap_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      trig_q <= trig;
    end
  end
`else
  logic unused_circ;

  assign circ_stop   = 1'b0;
  assign wrap_bit    = 1'b0;
  assign unused_circ = cfg_q[2];
`endif

  logic unused_ctrl;
  assign unused_ctrl = ^ctrl[31:4];

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= StIdle;
      en_q    <= 1'b0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      bdin_q  <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= ctrl[0];
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      bdin_q  <= bdin_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    baddr_d  = baddr_q;
    bdin_d   = bdin_q;
    last_d   = last_q;
    done_d   = done_q;
`ifdef SNAP_CIRC_EN
    wrap_d   = wrap_q;
`endif
    arm      = 1'b0;
    do_write = 1'b0;

    unique case (state_q)
      StIdle: begin
        arm = en_rise;
      end
      StArmed: begin
        if (!ctrl[0]) begin
          state_d = StDone;
        end else if (trig_hit) begin
          // The trigger cycle itself is the first capture cycle.
          state_d  = StCapture;
          do_write = qual;
        end
      end
      StCapture: begin
        if (!ctrl[0] || circ_stop) begin
          state_d = StDone;
        end else begin
          do_write = qual;
        end
      end
      StDone: begin
        done_d = 1'b1;
        arm    = en_rise;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_write) begin
      we_d    = 1'b1;
      baddr_d = cnt_q;
      bdin_d  = din;
      last_d  = cnt_q;
      if (cnt_q == AddrMax) begin
`ifdef SNAP_CIRC_EN
        if (cfg_q[2]) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          state_d = StDone;
        end
`else
        state_d = StDone;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (arm) begin
      state_d = StArmed;
      cfg_d   = ctrl[3:1];
      cnt_d   = '0;
      last_d  = '0;
      done_d  = 1'b0;
`ifdef SNAP_CIRC_EN
      wrap_d  = 1'b0;
`endif
    end
  end

  assign bram_we   = we_q;
  assign bram_addr = baddr_q;
  assign bram_din  = bdin_q;
  assign done      = done_q;
  assign addr_out  = {done_q, wrap_bit, {PadW{1'b0}}, last_q};

endmodule

// File: doc/tx10gbe_snap_capture.md
Name: tx10gbe_snap_capture

Overview:
- Capture controller directly upstream of the 10GbE TX snapshot address register.
- Watches the 64-bit 10GbE TX data stream and writes a triggered window into a snap BRAM.
- Drives the 32-bit capture-address/status word that software reads back over OPB through the simulink2ppc register.
- Runs entirely in the user_clk domain. Software arms it through a ppc2simulink control word.

Parameters:
- ADDR_W, 11: BRAM address width; window depth is 2^ADDR_W words.
- DATA_W, 64: captured data width.

Ports:
- user_clk  in  1: fabric clock; all logic is clocked on the rising edge.
- user_rst_n  in  1: reset, synchronous, active-low.
- ctrl  in  32: software control word.
  - bit0 enable
  - bit1 trig_src (0 = immediate, 1 = external trig)
  - bit2 we_src (0 = every cycle, 1 = din_valid only)
  - bit3 circ
  - other bits ignored
- din  in  DATA_W: TX data.
- din_valid  in  1: TX data valid.
- trig  in  1: external trigger; level is sampled each cycle.
- bram_addr  out  ADDR_W: snap BRAM write address.
- bram_din  out  DATA_W: snap BRAM write data.
- bram_we  out  1: snap BRAM write enable.
- addr_out  out  32: status word to the address register.
  - [31] done
  - [30] overflow-wrapped
  - [ADDR_W-1:0] last written address
  - all other bits 0
- done  out  1: capture complete; equals addr_out[31].

Behaviour:
- Reset (user_rst_n low at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including addr_out = 32'h0.
  - The internal address counter and the enable-edge register go to 0.
  - Reset mid-capture aborts the capture with no further writes.
- ctrl[0] is registered once; arming occurs on the detected 0->1 edge only. A level held high does not re-arm.
- States:
  - IDLE: wait for the enable rising edge. On the edge: counter = 0, addr_out = 0, go to ARMED.
  - ARMED: trigger is ctrl[1]==0, or trig==1 when ctrl[1]==1. The trigger cycle is itself a capture cycle. It writes if the write qualifier holds (ctrl[2]==0, or din_valid==1), then the state goes to CAPTURE.
  - CAPTURE: on each qualified cycle, write din at the counter value, then increment the counter.
    - A write at address 2^ADDR_W-1 ends the capture: go to DONE.
    - ctrl[0] low in CAPTURE (or ARMED) forces DONE on the next edge. It records the last address actually written. If nothing was written, addr_out[ADDR_W-1:0] = 0 and done = 1.
  - DONE: hold addr_out and done. A new enable rising edge (ctrl[0] 0->1) goes back to ARMED with the counter cleared and done cleared.
- Write pipeline:
  - din, the qualifier and the counter are registered once.
  - bram_we, bram_addr and bram_din appear one cycle after the qualifying input cycle.
  - bram_we is high for exactly one cycle per captured word.
- addr_out[ADDR_W-1:0] updates in the same cycle bram_we is asserted, to the address being written.
- addr_out[31] rises one cycle after the final write. It never precedes the final write's bram_we.
- The counter is ADDR_W bits and wraps only in circular mode (see Optional Feature). Otherwise it never exceeds 2^ADDR_W-1.
- Simultaneous trigger and enable edge in the same cycle: the edge arms; the trigger is evaluated from the next cycle.
- ctrl bits 1–3 are sampled on the arming edge and held for the whole capture.

Optional Feature:
- Macro SNAP_CIRC_EN.
- Defined, with ctrl[3]==1 at arming:
  - In CAPTURE the counter wraps from 2^ADDR_W-1 to 0 and writing continues.
  - addr_out[30] is set on the first wrap.
  - Capture ends only when ctrl[0] goes low or trig rises again (a 0->1 edge after entering CAPTURE), entering DONE.
  - addr_out[ADDR_W-1:0] then holds the last written address, so software reads the oldest word at that address +1.
- Not defined: ctrl[3] is ignored, addr_out[30] is tied to 0, and no wrap logic is synthesised.

Test Plan:
- Reset held 3 cycles with din toggling -> bram_we = 0, addr_out = 32'h0, done = 0 throughout.
- ctrl = 0x1 (immediate, every cycle), ADDR_W = 4, din = incrementing count from 0x100 -> 16 writes at addr 0..15 with data 0x100..0x10F. Then done = 1 and addr_out = 0x8000000F, with no write after the 16th.
- ctrl = 0x3, trig pulsed on the 5th cycle after arming -> first bram_we one cycle after the trig cycle, at addr 0 with data = din in the trig cycle.
- ctrl = 0x5, din_valid high on alternate cycles -> only valid words written at consecutive addresses; done after 2^ADDR_W valid words.
- Enable dropped after 6 writes -> DONE with addr_out = 0x80000005. Re-raising enable -> done clears, addr_out = 0, capture restarts at addr 0.
- With SNAP_CIRC_EN defined, ctrl = 0x9, ADDR_W = 4, run 20 writes then drop enable -> addr_out = 0xC0000003 (done, wrapped, last addr 3).
